fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I core.
- Sits directly upstream of the hazard unit: it consumes stall_F, stall_D, flush_D and pcsrc_E, and produces IR_D, which feeds decode and the hazard unit.
- Owns the program counter, the next-PC selection, the instruction-memory request handshake and bubble insertion on flush or memory wait.

---
 rtl/fetch_stage_if.sv | 21 ++
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, next-PC select, imem handshake and IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_F,
    input  logic               stall_D,
    input  logic               flush_D,
    input  logic               pcsrc_E,
    input  logic [31:0]        pc_target_E,
    fetch_stage_if.master      imem,
    output logic [31:0]        IR_D,
    output logic [31:0]        pc_D,
    output logic [31:0]        pc_plus4_D,
    output logic               valid_D,
    output logic               fetch_wait
);

    logic [31:0] pc_f_q, pc_f_d;
    logic        req_q;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_d_q, pc_d_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        fetch_ok;
    logic        unused_tgt;

    // Redirect targets are word-aligned; the low bits are intentionally ignored.
    assign unused_tgt = ^pc_target_E[1:0];

    assign fetch_ok = req_q & imem.imem_ready;

    always_comb begin
        pc_f_d = pc_f_q;
        if (pcsrc_E) begin
            pc_f_d = {pc_target_E[31:2], 2'b00};
        end else if (!stall_F && fetch_ok) begin
            pc_f_d = pc_f_q + 32'd4;
        end
    end

    always_comb begin
        ir_d    = ir_q;
        pc_d_d  = pc_d_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush_D) begin
            ir_d    = NOP_INSTR;
            valid_d = 1'b0;
        end else if (stall_D) begin
            // hold everything
        end else if (!fetch_ok) begin
            ir_d    = NOP_INSTR;
            valid_d = 1'b0;
        end else begin
            ir_d    = imem.imem_rdata;
            pc_d_d  = pc_f_q;
            pc4_d   = pc_f_q + 32'd4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_f_q  <= RESET_PC;
            req_q   <= 1'b0;
            ir_q    <= NOP_INSTR;
            pc_d_q  <= 32'd0;
            pc4_q   <= 32'd4;
            valid_q <= 1'b0;
        end else begin
            pc_f_q  <= pc_f_d;
            req_q   <= 1'b1;
            ir_q    <= ir_d;
            pc_d_q  <= pc_d_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_f_q;
    assign IR_D           = ir_q;
    assign pc_D           = pc_d_q;
    assign pc_plus4_D     = pc4_q;
    assign valid_D        = valid_q;
    assign fetch_wait     = req_q & ~imem.imem_ready;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage against a cycle-level behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_F = 1'b0, stall_D = 1'b0, flush_D = 1'b0, pcsrc_E = 1'b0;
    logic [31:0] pc_target_E = '0;
    logic [31:0] IR_D, pc_D, pc_plus4_D;
    logic        valid_D, fetch_wait;

    int checks   = 0;
    int failures = 0;

    // Model state: what the stage should hold after each edge.
    logic [31:0] m_pc, m_ir, m_pcd, m_pc4;
    logic        m_valid, m_req;

    fetch_stage_if bus ();

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    assign bus.imem_rdata = word_at(bus.imem_addr);

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall_F     (stall_F),
        .stall_D     (stall_D),
        .flush_D     (flush_D),
        .pcsrc_E     (pcsrc_E),
        .pc_target_E (pc_target_E),
        .imem        (bus.master),
        .IR_D        (IR_D),
        .pc_D        (pc_D),
        .pc_plus4_D  (pc_plus4_D),
        .valid_D     (valid_D),
        .fetch_wait  (fetch_wait)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_ir = NOP; m_pcd = 32'd0; m_pc4 = 32'd4; m_valid = 1'b0; m_req = 1'b0;
    endtask

    // One clock edge worth of architectural behaviour, using the inputs present at the edge.
    task automatic model_step();
        logic        got;
        logic [31:0] fetched_word, old_pc;
        old_pc       = m_pc;
        got          = m_req && bus.imem_ready;
        fetched_word = word_at(old_pc);
        if (pcsrc_E)                m_pc = pc_target_E & 32'hFFFF_FFFC;
        else if (!stall_F && got)   m_pc = old_pc + 32'd4;
        if (flush_D) begin
            m_ir = NOP; m_valid = 1'b0;
        end else if (!stall_D) begin
            if (got) begin
                m_ir = fetched_word; m_pcd = old_pc; m_pc4 = old_pc + 32'd4; m_valid = 1'b1;
            end else begin
                m_ir = NOP; m_valid = 1'b0;
            end
        end
        m_req = 1'b1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".req"},   {31'd0, bus.imem_req}, {31'd0, m_req});
        chk({tag, ".addr"},  bus.imem_addr, m_pc);
        chk({tag, ".ir"},    IR_D, m_ir);
        chk({tag, ".pcd"},   pc_D, m_pcd);
        chk({tag, ".pc4"},   pc_plus4_D, m_pc4);
        chk({tag, ".valid"}, {31'd0, valid_D}, {31'd0, m_valid});
        chk({tag, ".wait"},  {31'd0, fetch_wait}, {31'd0, m_req & ~bus.imem_ready});
    endtask

    task automatic cycle(input string tag, input logic pc_s, input logic [31:0] tgt,
                         input logic s_f, input logic s_d, input logic fl, input logic rdy);
        pcsrc_E = pc_s; pc_target_E = tgt; stall_F = s_f; stall_D = s_d; flush_D = fl;
        bus.imem_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        bus.imem_ready = 1'b1;
        model_reset();
        #12;
        check_all("reset");
        chk("reset.ir_nop", IR_D, 32'h0000_0013);
        @(negedge clk);
        rst = 1'b1;

        // Streaming fetch from reset
        for (int i = 0; i < 5; i++) cycle("stream", 0, 0, 0, 0, 0, 1);
        chk("stream.at10", bus.imem_addr, 32'h10);
        chk("stream.ir0c", IR_D, word_at(32'h0C));

        // Load-use style stall
        for (int i = 0; i < 2; i++) cycle("stall", 0, 0, 1, 1, 0, 1);
        chk("stall.addr", bus.imem_addr, 32'h10);
        chk("stall.pcd", pc_D, 32'h0C);
        cycle("resume", 0, 0, 0, 0, 0, 1);
        chk("resume.ir10", IR_D, word_at(32'h10));
        cycle("resume", 0, 0, 0, 0, 0, 1);
        chk("resume.ir14", IR_D, word_at(32'h14));

        // Advance to 0x20 then branch to 0x103
        for (int i = 0; i < 8 && m_pc != 32'h20; i++) cycle("to20", 0, 0, 0, 0, 0, 1);
        chk("to20.addr", bus.imem_addr, 32'h20);
        cycle("branch", 1, 32'h103, 0, 0, 1, 1);
        chk("branch.addr", bus.imem_addr, 32'h100);
        chk("branch.valid", {31'd0, valid_D}, 32'd0);
        cycle("branch", 0, 0, 0, 0, 0, 1);
        chk("branch.ir100", IR_D, word_at(32'h100));
        chk("branch.pcd", pc_D, 32'h100);

        // Memory wait at 0x40
        cycle("to40", 1, 32'h40, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cycle("wait", 0, 0, 0, 0, 0, 0);
        chk("wait.addr", bus.imem_addr, 32'h40);
        chk("wait.flag", {31'd0, fetch_wait}, 32'd1);
        cycle("wait_done", 0, 0, 0, 0, 0, 1);
        chk("wait_done.ir40", IR_D, word_at(32'h40));
        cycle("wait_done", 0, 0, 0, 0, 0, 1);
        chk("wait_done.pcd", pc_D, 32'h44);

        // Waiting fetch abandoned by redirect
        cycle("to40b", 1, 32'h40, 0, 0, 1, 1);
        cycle("abandon", 1, 32'h80, 0, 0, 0, 0);
        chk("abandon.addr", bus.imem_addr, 32'h80);
        cycle("abandon", 0, 0, 0, 0, 0, 1);
        chk("abandon.ir80", IR_D, word_at(32'h80));

        // Async reset mid-stall at 0x200
        cycle("to200", 1, 32'h200, 0, 0, 1, 1);
        cycle("stall200", 0, 0, 1, 1, 0, 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rst = 1'b1;
        stall_F = 1'b0; stall_D = 1'b0;
        cycle("restart", 0, 0, 0, 0, 0, 1);
        cycle("restart", 0, 0, 0, 0, 0, 1);
        chk("restart.ir0", IR_D, word_at(32'h0));

        // PC wrap
        cycle("towrap", 1, 32'hFFFF_FFFE, 0, 0, 1, 1);
        chk("towrap.addr", bus.imem_addr, 32'hFFFF_FFFC);
        cycle("wrap", 0, 0, 0, 0, 0, 1);
        chk("wrap.addr", bus.imem_addr, 32'h0);
        chk("wrap.pc4", pc_plus4_D, 32'h0);

        // Randomized mixture of hazards, redirects and memory waits
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  ($urandom_range(0, 9) == 0),
                  $urandom,
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
